// File: rtl/ysyx_23060332_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, func3 size codes and
// the alignment rule used to reject misaligned accesses.
package ysyx_23060332_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    WB   = 2'd3
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Halfwords need an even address, words a multiple of four; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] off);
    return ((func3[1:0] == 2'b01) && off[0]) ||
           ((func3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060332_lsu_align.sv
// Byte-lane logic: store mask/data replication and load extract/extend.
module ysyx_23060332_lsu_align
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        off,
  input  logic [2:0]        func3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        wmask,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    wmask      = 4'b1111;
    wdata_lane = wdata;
    case (func3)
      SB: begin
        wmask      = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      SH: begin
        wmask      = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = shifted;
    case (func3)
      LB:      rdata_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      LH:      rdata_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      LBU:     rdata_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      LHU:     rdata_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_23060332_lsu.sv
// Multi-cycle load/store unit: captures one execute-stage operation, runs a
// valid/ready memory request/response and presents one writeback beat.
module ysyx_23060332_lsu
  import ysyx_23060332_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_ren_i,
  input  logic              mem_wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [2:0]        func3_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [4:0]        waddr_i,
  input  logic              reg_wen_i,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              reg_wen_o,
  output logic              misalign_o
);

  lsu_state_e        state, state_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        func3_q;
  logic              accept, mem_op, misaligned;
  logic [3:0]        lane_mask;
  logic [DATA_W-1:0] lane_wdata, load_data;

  assign accept     = (state == IDLE) && in_valid;
  assign mem_op     = mem_ren_i || mem_wen_i;
  assign misaligned = mem_op && is_misaligned(func3_i, addr_i[1:0]);

  ysyx_23060332_lsu_align #(.DATA_W(DATA_W)) u_align (
    .off        (addr_q[1:0]),
    .func3      (func3_q),
    .wdata      (wdata_q),
    .rdata      (mem_rsp_rdata),
    .wmask      (lane_mask),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_data)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = (mem_op && !misaligned) ? REQ : WB;
      REQ:  if (mem_req_ready) state_n = RESP;
      RESP: if (mem_rsp_valid) state_n = WB;
      WB:   if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      func3_q    <= 3'b000;
      waddr_o    <= 5'd0;
      wdata_o    <= '0;
      reg_wen_o  <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_n;
      misalign_o <= 1'b0;
      if (accept) begin
        we_q       <= mem_wen_i;
        addr_q     <= addr_i;
        wdata_q    <= wdata_i;
        func3_q    <= func3_i;
        waddr_o    <= waddr_i;
        wdata_o    <= alu_result_i;
        // Stores and trapped accesses never write back; x0 is never written.
        reg_wen_o  <= reg_wen_i && (waddr_i != 5'd0) && !mem_wen_i && !misaligned;
        misalign_o <= misaligned;
      end
      if ((state == RESP) && mem_rsp_valid && !we_q) wdata_o <= load_data;
    end
  end

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == WB);
  assign mem_req_valid = (state == REQ);
  assign mem_req_we    = mem_req_valid && we_q;
  assign mem_req_addr  = mem_req_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_req_wdata = mem_req_we ? lane_wdata : '0;
  assign mem_req_wmask = mem_req_we ? {4'b0000, lane_mask} : 8'h00;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for the LSU: expected writeback beats are queued when an
// operation is issued and compared when the DUT presents them.
module tb_ysyx_23060332_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_ren_i = 1'b0;
  logic        mem_wen_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [2:0]  func3_i = '0;
  logic [31:0] alu_result_i = '0;
  logic [4:0]  waddr_i = '0;
  logic        reg_wen_i = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        reg_wen_o;
  logic        misalign_o;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        reg_wen;
    logic        misalign;
    logic        chk_data;
  } wb_t;

  wb_t sb_q[$];
  int  pass_cnt  = 0;
  int  fail_cnt  = 0;
  int  total_cnt = 0;

  ysyx_23060332_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .func3_i(func3_i),
    .alu_result_i(alu_result_i), .waddr_i(waddr_i), .reg_wen_i(reg_wen_i),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .reg_wen_o(reg_wen_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] wa, input logic [31:0] wd, input logic rw,
                      input logic mis, input logic chk);
    wb_t e;
    e.waddr = wa; e.wdata = wd; e.reg_wen = rw; e.misalign = mis; e.chk_data = chk;
    sb_q.push_back(e);
  endtask

  // Starts and ends just after a falling edge; the DUT accepts on the rising edge between.
  task automatic accept(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] alu,
                        input logic [4:0] wa, input logic rw);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_ren_i = ren; mem_wen_i = wen; addr_i = addr; wdata_i = wd;
    func3_i = f3; alu_result_i = alu; waddr_i = wa; reg_wen_i = rw;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; mem_ren_i = 1'b0; mem_wen_i = 1'b0;
  endtask

  task automatic run_mem(input int hold, input logic [31:0] rdata, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] wm);
    check("req_valid", 32'(mem_req_valid), 32'd1);
    check("req_we", 32'(mem_req_we), 32'(we));
    check("req_addr", mem_req_addr, addr);
    check("req_wdata", mem_req_wdata, wd);
    check("req_wmask", 32'(mem_req_wmask), 32'(wm));
    for (int i = 0; i < hold; i++) begin
      mem_req_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("req_hold_valid", 32'(mem_req_valid), 32'd1);
      check("req_hold_addr", mem_req_addr, addr);
      check("req_hold_wdata", mem_req_wdata, wd);
      check("req_hold_wmask", 32'(mem_req_wmask), 32'(wm));
      check("req_hold_in_ready", 32'(in_ready), 32'd0);
    end
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("req_dropped", 32'(mem_req_valid), 32'd0);
    check("resp_no_out", 32'(out_valid), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
  endtask

  task automatic wait_wb(input int hold);
    wb_t e;
    check("out_valid", 32'(out_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check("scoreboard_nonempty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("wb_waddr", 32'(waddr_o), 32'(e.waddr));
    if (e.chk_data) check("wb_wdata", wdata_o, e.wdata);
    check("wb_reg_wen", 32'(reg_wen_o), 32'(e.reg_wen));
    check("wb_misalign", 32'(misalign_o), 32'(e.misalign));
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("wb_hold_valid", 32'(out_valid), 32'd1);
      if (e.chk_data) check("wb_hold_wdata", wdata_o, e.wdata);
      check("wb_hold_reg_wen", 32'(reg_wen_o), 32'(e.reg_wen));
      check("wb_hold_in_ready", 32'(in_ready), 32'd0);
      check("wb_misalign_once", 32'(misalign_o), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("wb_done_valid", 32'(out_valid), 32'd0);
    check("wb_done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_wdata_o", wdata_o, 32'd0);
    check("rst_reg_wen", 32'(reg_wen_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory pass-through: writeback the cycle after accept
    push(5'd5, 32'h0000_1234, 1'b1, 1'b0, 1'b1);
    accept(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, 32'h0000_1234, 5'd5, 1'b1);
    check("alu_no_req", 32'(mem_req_valid), 32'd0);
    wait_wb(0);

    // Byte loads from the top lane, signed and unsigned
    push(5'd8, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 32'h8000_0003, 32'h0, 3'b000, 32'hDEAD, 5'd8, 1'b1);
    run_mem(0, 32'h80FF_0000, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
    wait_wb(0);
    push(5'd8, 32'h0000_0080, 1'b1, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 32'h8000_0003, 32'h0, 3'b100, 32'hDEAD, 5'd8, 1'b1);
    run_mem(0, 32'h80FF_0000, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
    wait_wb(0);

    // Halfword loads from the upper half
    push(5'd10, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b001, 32'h0, 5'd10, 1'b1);
    run_mem(0, 32'h80FF_0000, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
    wait_wb(0);
    push(5'd10, 32'h0000_80FF, 1'b1, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b101, 32'h0, 5'd10, 1'b1);
    run_mem(0, 32'h80FF_0000, 1'b0, 32'h8000_0000, 32'h0, 8'h00);
    wait_wb(0);

    // Halfword store into the upper lanes
    push(5'd9, 32'h0, 1'b0, 1'b0, 1'b0);
    accept(1'b0, 1'b1, 32'h8000_0002, 32'hABCD_1234, 3'b001, 32'h0, 5'd9, 1'b1);
    run_mem(0, 32'h0, 1'b1, 32'h8000_0000, 32'h1234_1234, 8'h0C);
    wait_wb(0);

    // Load and store both set behaves as a byte store
    push(5'd11, 32'h0, 1'b0, 1'b0, 1'b0);
    accept(1'b1, 1'b1, 32'h8000_0001, 32'h0000_00A5, 3'b000, 32'h0, 5'd11, 1'b1);
    run_mem(0, 32'h0, 1'b1, 32'h8000_0000, 32'hA5A5_A5A5, 8'h02);
    wait_wb(0);

    // Backpressure on both the request and the writeback side
    push(5'd7, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 32'h8000_0004, 32'h0, 3'b010, 32'h0, 5'd7, 1'b1);
    run_mem(3, 32'hDEAD_BEEF, 1'b0, 32'h8000_0004, 32'h0, 8'h00);
    wait_wb(2);

    // Misaligned word: no memory traffic, one misalign pulse, no register write
    push(5'd3, 32'h0, 1'b0, 1'b1, 1'b0);
    accept(1'b1, 1'b0, 32'h8000_0002, 32'h0, 3'b010, 32'h0, 5'd3, 1'b1);
    check("misalign_no_req", 32'(mem_req_valid), 32'd0);
    wait_wb(1);

    // Load to x0 never enables the register write
    push(5'd0, 32'h55AA_55AA, 1'b0, 1'b0, 1'b1);
    accept(1'b1, 1'b0, 32'h8000_0008, 32'h0, 3'b010, 32'h0, 5'd0, 1'b1);
    run_mem(0, 32'h55AA_55AA, 1'b0, 32'h8000_0008, 32'h0, 8'h00);
    wait_wb(0);

    // Reset while waiting for the response; the late response is dropped
    accept(1'b1, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 32'h0, 5'd4, 1'b1);
    check("abort_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_wdata_o", wdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    check("late_rsp_out_valid", 32'(out_valid), 32'd0);
    check("late_rsp_in_ready", 32'(in_ready), 32'd1);
    check("late_rsp_wdata_o", wdata_o, 32'd0);
    check("late_rsp_reg_wen", 32'(reg_wen_o), 32'd0);

    push(5'd6, 32'h0000_0077, 1'b1, 1'b0, 1'b1);
    accept(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 32'h0000_0077, 5'd6, 1'b1);
    wait_wb(0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
